// File: rtl/mic_acq_ctrl.sv
// Microphone acquisition burst sequencer: gates the PDM mic clock, holds the PCM
// divider in reset while idle, discards warm-up ticks, then strobes N samples.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | mic clock off, PCM divider in reset, waiting for start
// ARM     | one cycle: mic clock on, prescaler presented, divider in reset
// WARMUP  | divider running, ce_pcm ticks discarded
// CAPTURE | each ce_pcm strobes one sample one cycle later
// DONE    | one cycle: done pulse, last sample strobe, mic clock off
module mic_acq_ctrl #(
  parameter int PRESC_W = 10,
  parameter int WARM_W  = 16,
  parameter int CNT_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PRESC_W-1:0] cfg_prescaler,
  input  logic [WARM_W-1:0]  cfg_warmup,
  input  logic [CNT_W-1:0]   cfg_nsamples,
  input  logic               ce_pcm,
  output logic               mic_en,
  output logic               pcm_rst,
  output logic [PRESC_W-1:0] prescaler,
  output logic               sample_we,
  output logic [CNT_W-1:0]   sample_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WARMUP,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            state_q, state_nxt;
  logic [WARM_W-1:0] warm_sh, warm_cnt;
  logic [CNT_W-1:0]  nsamp_sh, idx_cnt;
  logic              accept, cap_tick;

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    cap_tick  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (abort)              state_nxt = S_IDLE;
        else if (warm_sh == '0) state_nxt = S_CAPTURE;
        else                    state_nxt = S_WARMUP;
      end
      S_WARMUP: begin
        if (abort)                                     state_nxt = S_IDLE;
        else if (ce_pcm && warm_cnt == WARM_W'(1))     state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (ce_pcm) begin
          cap_tick = 1'b1;
          // nsamples == 0 means continuous: never reaches DONE
          if (nsamp_sh != '0 && idx_cnt == nsamp_sh - CNT_W'(1))
            state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      warm_sh    <= '0;
      nsamp_sh   <= '0;
      warm_cnt   <= '0;
      idx_cnt    <= '0;
      prescaler  <= '0;
      mic_en     <= 1'b0;
      pcm_rst    <= 1'b1;
      sample_we  <= 1'b0;
      sample_idx <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if (accept) begin
        prescaler <= cfg_prescaler;
        warm_sh   <= cfg_warmup;
        nsamp_sh  <= cfg_nsamples;
        err       <= 1'b0;
      end else if (start && state_q != S_IDLE) begin
        err <= 1'b1;
      end

      if (state_q == S_ARM) begin
        warm_cnt <= warm_sh;
        idx_cnt  <= '0;
      end else if (state_q == S_WARMUP && ce_pcm && !abort) begin
        warm_cnt <= warm_cnt - WARM_W'(1);
      end else if (cap_tick) begin
        idx_cnt <= idx_cnt + CNT_W'(1);
      end

      sample_we <= cap_tick;
      if (cap_tick) sample_idx <= idx_cnt;

      // Status outputs are registered from the next state so they line up with it
      mic_en  <= (state_nxt == S_ARM) || (state_nxt == S_WARMUP) || (state_nxt == S_CAPTURE);
      pcm_rst <= !((state_nxt == S_WARMUP) || (state_nxt == S_CAPTURE));
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_mic_acq_ctrl.sv
// Directed bench for mic_acq_ctrl; a second instance with CNT_W=3 covers index wrap.
module tb_mic_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, ce_pcm;
  logic [9:0]  cfg_prescaler;
  logic [15:0] cfg_warmup;
  logic [11:0] cfg_nsamples;
  logic        mic_en, pcm_rst, sample_we, busy, done, err;
  logic [9:0]  prescaler;
  logic [11:0] sample_idx;

  logic        start_w, abort_w;
  logic [2:0]  cfg_nsamples_w;
  logic        mic_en_w, pcm_rst_w, sample_we_w, busy_w, done_w, err_w;
  logic [9:0]  prescaler_w;
  logic [2:0]  sample_idx_w;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int we_cnt   = 0;
  int d0, w0;

  always #5 clk = ~clk;

  mic_acq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_prescaler(cfg_prescaler), .cfg_warmup(cfg_warmup), .cfg_nsamples(cfg_nsamples),
    .ce_pcm(ce_pcm), .mic_en(mic_en), .pcm_rst(pcm_rst), .prescaler(prescaler),
    .sample_we(sample_we), .sample_idx(sample_idx), .busy(busy), .done(done), .err(err)
  );

  mic_acq_ctrl #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .abort(abort_w),
    .cfg_prescaler(cfg_prescaler), .cfg_warmup(cfg_warmup), .cfg_nsamples(cfg_nsamples_w),
    .ce_pcm(ce_pcm), .mic_en(mic_en_w), .pcm_rst(pcm_rst_w), .prescaler(prescaler_w),
    .sample_we(sample_we_w), .sample_idx(sample_idx_w), .busy(busy_w), .done(done_w), .err(err_w)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (sample_we) we_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ce_pcm = 1'b1;
    step();
    ce_pcm = 1'b0;
  endtask

  task automatic cfg(input int p, input int w, input int n);
    cfg_prescaler = 10'(p);
    cfg_warmup    = 16'(w);
    cfg_nsamples  = 12'(n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ce_pcm = 1'b0;
    start_w = 1'b0; abort_w = 1'b0; cfg_nsamples_w = 3'd0;
    cfg(0, 0, 0);
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_mic_en", mic_en, 0);
    check("rst_pcm_rst", pcm_rst, 1);
    check("rst_prescaler", prescaler, 0);
    check("rst_we", sample_we, 0);
    check("rst_idx", sample_idx, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    step();

    // start together with abort in IDLE does not launch
    cfg(5, 2, 4);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_err", err, 0);

    // single burst: prescaler 3, warmup 2, 4 samples, tick every 4 cycles
    cfg(3, 2, 4);
    d0 = done_cnt; w0 = we_cnt;
    start = 1'b1; step(); start = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_mic_en", mic_en, 1);
    check("arm_pcm_rst", pcm_rst, 1);
    check("arm_prescaler", prescaler, 3);
    step();
    check("warm_pcm_rst", pcm_rst, 0);
    check("warm_mic_en", mic_en, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("b1_we", sample_we, (k >= 2) ? 1 : 0);
      if (k >= 2) check("b1_idx", sample_idx, k - 2);
      check("b1_done", done, (k == 5) ? 1 : 0);
      if (k == 5) begin
        check("b1_done_mic_en", mic_en, 0);
        check("b1_done_pcm_rst", pcm_rst, 1);
        check("b1_done_busy", busy, 1);
      end
      step();
      check("b1_we_gap", sample_we, 0);
      if (k == 5) begin
        check("b1_busy_after", busy, 0);
        check("b1_done_after", done, 0);
      end
      step(); step();
    end
    check("b1_we_count", we_cnt - w0, 4);
    check("b1_done_count", done_cnt - d0, 1);

    // no warm-up, single sample
    cfg(3, 0, 1);
    start = 1'b1; step(); start = 1'b0;
    check("nw_arm_pcm_rst", pcm_rst, 1);
    step();
    check("nw_cap_pcm_rst", pcm_rst, 0);
    check("nw_cap_mic_en", mic_en, 1);
    tick();
    check("nw_we", sample_we, 1);
    check("nw_idx", sample_idx, 0);
    check("nw_done", done, 1);
    check("nw_mic_en", mic_en, 0);
    step();
    check("nw_busy_after", busy, 0);

    // abort coincident with the third capture tick
    cfg(3, 0, 8);
    d0 = done_cnt; w0 = we_cnt;
    start = 1'b1; step(); start = 1'b0;
    step();
    tick();
    check("ab_idx0", sample_idx, 0);
    step();
    tick();
    check("ab_idx1", sample_idx, 1);
    step();
    ce_pcm = 1'b1; abort = 1'b1; step(); ce_pcm = 1'b0; abort = 1'b0;
    check("ab_we", sample_we, 0);
    check("ab_busy", busy, 0);
    check("ab_mic_en", mic_en, 0);
    check("ab_pcm_rst", pcm_rst, 1);
    step();
    check("ab_we_count", we_cnt - w0, 2);
    check("ab_done_count", done_cnt - d0, 0);

    // continuous mode on the 3-bit index instance
    cfg(3, 0, 0);
    cfg_nsamples_w = 3'd0;
    start_w = 1'b1; step(); start_w = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("cont_we", sample_we_w, 1);
      check("cont_idx", sample_idx_w, i % 8);
      check("cont_busy", busy_w, 1);
      step();
    end
    abort_w = 1'b1; step(); abort_w = 1'b0;
    check("cont_abort_busy", busy_w, 0);
    check("cont_abort_mic_en", mic_en_w, 0);
    check("cont_done", done_w, 0);

    // protocol errors: start while busy, cfg change mid-burst, start in DONE
    cfg(3, 1, 2);
    start = 1'b1; step(); start = 1'b0;
    check("pe_err_clear", err, 0);
    step();
    start = 1'b1; step(); start = 1'b0;
    check("pe_err_set", err, 1);
    check("pe_busy", busy, 1);
    cfg_prescaler = 10'd9;
    tick();
    check("pe_prescaler_hold", prescaler, 3);
    tick();
    check("pe_idx0", sample_idx, 0);
    tick();
    check("pe_idx1", sample_idx, 1);
    check("pe_done", done, 1);
    start = 1'b1; step(); start = 1'b0;
    check("pe_done_start_busy", busy, 0);
    check("pe_done_start_err", err, 1);
    start = 1'b1; step(); start = 1'b0;
    check("pe_restart_busy", busy, 1);
    check("pe_restart_err", err, 0);
    check("pe_restart_prescaler", prescaler, 9);
    abort = 1'b1; step(); abort = 1'b0;
    check("pe_abort_busy", busy, 0);

    // synchronous reset mid-WARMUP, then a full burst
    cfg(3, 5, 2);
    start = 1'b1; step();
    step(); start = 1'b0;
    check("sr_err_pre", err, 1);
    tick();
    rst = 1'b1; step(); rst = 1'b0;
    check("sr_busy", busy, 0);
    check("sr_mic_en", mic_en, 0);
    check("sr_pcm_rst", pcm_rst, 1);
    check("sr_prescaler", prescaler, 0);
    check("sr_err", err, 0);
    check("sr_done", done, 0);
    check("sr_we", sample_we, 0);
    check("sr_idx", sample_idx, 0);
    cfg(3, 1, 2);
    d0 = done_cnt; w0 = we_cnt;
    start = 1'b1; step(); start = 1'b0;
    step();
    tick();
    tick();
    check("sr_idx0", sample_idx, 0);
    tick();
    check("sr_idx1", sample_idx, 1);
    check("sr_done_pulse", done, 1);
    step();
    check("sr_busy_after", busy, 0);
    check("sr_we_count", we_cnt - w0, 2);
    check("sr_done_count", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
